// File: rtl/cache_miss_handler.sv
// cache_miss_handler
// Responder side of the cache miss interface. Queues line-fill requests from
// the cache, fetches each line as 2**BLK_W in-order word reads from the
// memory read port, assembles the words into a line and hands the line back
// to the cache. Only one line is in flight at a time, and lines are returned
// in request order.
// Optional build macro: MH_PERF_CNT_EN adds the perf_lines/perf_stall
// profiling counter outputs.
module cache_miss_handler #(
  parameter int ADDR_W    = 25,
  parameter int BLK_W     = 2,
  parameter int WORD_W    = 32,
  parameter int RDATA_W   = 128,
  parameter int REQ_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ADDR_W-1:0]  to_mh_addr,
  input  logic               to_mh_valid,
  output logic               from_mh_stall,
  output logic [RDATA_W-1:0] from_mh_data,
  output logic               from_mh_valid,
  input  logic               to_mh_stall,
  output logic               mem_rd_req,
  output logic [ADDR_W-1:0]  mem_rd_addr,
  input  logic               mem_rd_ack,
  input  logic [WORD_W-1:0]  mem_rd_data,
  input  logic               mem_rd_valid
`ifdef MH_PERF_CNT_EN
  ,
  output logic [31:0]        perf_lines,
  output logic [31:0]        perf_stall
`endif
);

  localparam int WPL    = 2 ** BLK_W;
  localparam int LINE_W = ADDR_W - BLK_W;
  localparam int PTR_W  = $clog2(REQ_DEPTH);

  localparam logic [BLK_W:0] WPL_IDX   = (BLK_W + 1)'(WPL);
  localparam logic [BLK_W:0] LAST_IDX  = (BLK_W + 1)'(WPL - 1);
  localparam logic [BLK_W:0] ONE_IDX   = (BLK_W + 1)'(1);
  localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W + 1)'(REQ_DEPTH);
  localparam logic [PTR_W:0] ONE_CNT   = (PTR_W + 1)'(1);
  localparam logic [PTR_W-1:0] ONE_PTR = PTR_W'(1);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    RESP
  } state_t;

  logic [LINE_W-1:0] fifo_mem [REQ_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W:0]    count;
  logic              push;
  logic              pop;
  logic [LINE_W-1:0] head;

  state_t            state;
  logic [BLK_W:0]    issue_idx;
  logic [BLK_W:0]    ret_idx;
  logic [BLK_W:0]    issue_next;
  logic [BLK_W:0]    ret_next;
  logic              word_accept;

  // The cache only sends line-aligned requests; the word offset is dropped.
  logic [BLK_W-1:0]  unused_offset;

  assign unused_offset = to_mh_addr[BLK_W-1:0];

  // Stall comes straight from the registered count, so a pop in the same
  // cycle does not release it until the following cycle.
  assign from_mh_stall = (count == DEPTH_CNT);
  assign push          = to_mh_valid & ~from_mh_stall;
  assign pop           = (state == RESP) & ~to_mh_stall;
  assign head          = fifo_mem[rd_ptr];
  assign issue_next    = issue_idx + ONE_IDX;
  assign ret_next      = ret_idx + ONE_IDX;
  // Returned words are only meaningful while a line is being fetched.
  assign word_accept   = (state == FETCH) & mem_rd_valid & (ret_idx < WPL_IDX);

  // Request FIFO storage; entries hold the line address only.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= to_mh_addr[ADDR_W-1:BLK_W];
    end
  end

  // Request FIFO pointers and occupancy; push and pop may coincide.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + ONE_PTR;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + ONE_PTR;
      end
      case ({push, pop})
        2'b10:   count <= count + ONE_CNT;
        2'b01:   count <= count - ONE_CNT;
        default: count <= count;
      endcase
    end
  end

  // Line-fill sequencer: issues word reads, collects returns, presents the line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      issue_idx     <= '0;
      ret_idx       <= '0;
      mem_rd_req    <= 1'b0;
      mem_rd_addr   <= '0;
      from_mh_valid <= 1'b0;
      from_mh_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (count != '0) begin
            state       <= FETCH;
            issue_idx   <= '0;
            ret_idx     <= '0;
            mem_rd_req  <= 1'b1;
            mem_rd_addr <= {head, BLK_W'(0)};
          end
        end
        FETCH: begin
          if (mem_rd_req && mem_rd_ack) begin
            issue_idx <= issue_next;
            if (issue_next == WPL_IDX) begin
              mem_rd_req <= 1'b0;
            end else begin
              mem_rd_addr <= {head, issue_next[BLK_W-1:0]};
            end
          end
          if (word_accept) begin
            from_mh_data[ret_idx[BLK_W-1:0]*WORD_W +: WORD_W] <= mem_rd_data;
            ret_idx <= ret_next;
            if (ret_idx == LAST_IDX) begin
              state         <= RESP;
              from_mh_valid <= 1'b1;
            end
          end
        end
        RESP: begin
          if (!to_mh_stall) begin
            from_mh_valid <= 1'b0;
            state         <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef MH_PERF_CNT_EN
  // Profiling counters: delivered lines and cycles spent waiting on the cache.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_lines <= '0;
      perf_stall <= '0;
    end else if (from_mh_valid) begin
      if (to_mh_stall) begin
        perf_stall <= perf_stall + 32'd1;
      end else begin
        perf_lines <= perf_lines + 32'd1;
      end
    end
  end
`else
  // Profiling counters are compiled out in this build.
`endif

endmodule
